// File: rtl/des_pkg.sv
// Shared DES tables, state encoding and permutation helpers for des_iter_core.
// Bit numbering follows the standard: table entry 1 maps to the MSB of the vector.
package des_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Left-rotation amount applied before each encryption round.
    localparam logic [1:0] SHIFTS [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    // Each row is indexed by {b1,b6,b2,b3,b4,b5} of the 6-bit S-box input.
    localparam logic [3:0] SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [27:0] rotate(input logic [27:0] x, input logic [1:0] amt,
                                           input logic right);
        logic [27:0] y;
        case ({right, amt})
            3'b001:  y = {x[26:0], x[27]};
            3'b010:  y = {x[25:0], x[27:26]};
            3'b101:  y = {x[0], x[27:1]};
            3'b110:  y = {x[1:0], x[27:2]};
            default: y = x;
        endcase
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        x = '0;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            b = x[47-6*i -: 6];
            s[31-4*i -: 4] = SBOX[i][{b[5], b[0], b[4:1]}];
        end
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES round: key-schedule rotation, PC2 subkey and Feistel step.
// Decryption walks the schedule backwards, so it rotates right by the mirrored amount.
module des_round
    import des_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [27:0] c,
    input  logic [27:0] d,
    input  logic [3:0]  round,
    input  logic        decrypt,
    output logic [31:0] l_next,
    output logic [31:0] r_next,
    output logic [27:0] c_next,
    output logic [27:0] d_next
);

    logic [3:0]  dec_idx;
    logic [1:0]  amt;
    logic [27:0] c_rot;
    logic [27:0] d_rot;
    logic [47:0] subkey;

    // Decrypt round k undoes the encryption shift of round 18-k; wrap gives 16-round.
    always_comb begin
        dec_idx = 4'd0 - round;
        if (decrypt)
            amt = (round == 4'd0) ? 2'd0 : SHIFTS[dec_idx];
        else
            amt = SHIFTS[round];
        c_rot  = rotate(c, amt, decrypt);
        d_rot  = rotate(d, amt, decrypt);
        subkey = pc2({c_rot, d_rot});
        l_next = r;
        r_next = l ^ feistel(r, subkey);
        c_next = c_rot;
        d_next = d_rot;
    end

endmodule

// File: rtl/des_iter_core.sv
// Iterative DES encrypt/decrypt core with valid/ready handshakes on both sides.
// Optional macro DES_ZEROIZE_EN clears the result and working registers after hand-off.
module des_iter_core
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] key,
    input  logic [63:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out,
    output logic        busy
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] RPC      = 5'(ROUNDS_PER_CYCLE);
    localparam logic [4:0] LAST_CNT = 5'(16 - ROUNDS_PER_CYCLE);

    state_t      state;
    state_t      state_next;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [4:0]  cnt;
    logic        mode;
    logic        accept;
    logic        last_step;
    logic [63:0] ip_in;
    logic [55:0] pc1_key;

    logic [31:0] l_ch [ROUNDS_PER_CYCLE+1];
    logic [31:0] r_ch [ROUNDS_PER_CYCLE+1];
    logic [27:0] c_ch [ROUNDS_PER_CYCLE+1];
    logic [27:0] d_ch [ROUNDS_PER_CYCLE+1];

    assign ip_in     = ip(data_in);
    assign pc1_key   = pc1(key);
    assign accept    = in_valid & in_ready;
    assign last_step = (state == RUN) && (cnt == LAST_CNT);

    assign l_ch[0] = l_q;
    assign r_ch[0] = r_q;
    assign c_ch[0] = c_q;
    assign d_ch[0] = d_q;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        des_round u_round (
            .l       (l_ch[g]),
            .r       (r_ch[g]),
            .c       (c_ch[g]),
            .d       (d_ch[g]),
            .round   (cnt[3:0] + 4'(g)),
            .decrypt (mode),
            .l_next  (l_ch[g+1]),
            .r_next  (r_ch[g+1]),
            .c_next  (c_ch[g+1]),
            .d_next  (d_ch[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // In DONE the input side is ready only when the result is being taken this cycle.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_next = in_valid ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            cnt      <= '0;
            mode     <= 1'b0;
            data_out <= '0;
        end else if (accept) begin
            {l_q, r_q} <= ip_in;
            {c_q, d_q} <= pc1_key;
            mode       <= in_decrypt;
            cnt        <= '0;
        end else if (state == RUN) begin
            l_q <= l_ch[ROUNDS_PER_CYCLE];
            r_q <= r_ch[ROUNDS_PER_CYCLE];
            c_q <= c_ch[ROUNDS_PER_CYCLE];
            d_q <= d_ch[ROUNDS_PER_CYCLE];
            cnt <= cnt + RPC;
            if (last_step)
                data_out <= fp({r_ch[ROUNDS_PER_CYCLE], l_ch[ROUNDS_PER_CYCLE]});
        end else if (state == DONE && out_ready) begin
`ifdef DES_ZEROIZE_EN
            data_out <= '0;
            l_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
`else
            data_out <= data_out;
`endif
        end
    end

endmodule

// File: tb/tb_des_iter_core.sv
// Directed bench for des_iter_core: known-answer vectors, latency, backpressure and reset.
module tb_des_iter_core;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2 = 64'h8787878787878787;
    localparam logic [63:0] C2 = 64'h0000000000000000;
    localparam int RV [4] = '{2, 4, 8, 16};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
    logic [63:0] key, data_in, data_out;

    logic        in_valid_m, in_decrypt_m, out_ready_m;
    logic [63:0] key_m, data_in_m;
    logic [3:0]  in_ready_m, out_valid_m, busy_m;
    logic [63:0] data_out_m [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    des_iter_core #(.ROUNDS_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_decrypt(in_decrypt), .key(key), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_multi
        des_iter_core #(.ROUNDS_PER_CYCLE(RV[g])) u_dut_m (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready_m[g]),
            .in_decrypt(in_decrypt_m), .key(key_m), .data_in(data_in_m),
            .out_valid(out_valid_m[g]), .out_ready(out_ready_m),
            .data_out(data_out_m[g]), .busy(busy_m[g])
        );
    end

    function automatic logic [63:0] status(input logic b, input logic ov, input logic ir);
        return {61'd0, b, ov, ir};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents one block for a single edge; caller sets out_ready as needed.
    task automatic applyStimulus(input logic [63:0] k, input logic [63:0] d, input logic dec);
        key        = k;
        data_in    = d;
        in_decrypt = dec;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        key      = '1;
        data_in  = '1;
    endtask

    task automatic waitResult(input int limit, output int cycles);
        cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        logic ov_seen;
        logic [63:0] vk [2];
        logic [63:0] vp [2];
        logic [63:0] vc [2];
        int lat [4];

        vk = '{K2, K1};
        vp = '{P2, P1};
        vc = '{C2, C1};

        rst_n = 1'b0;
        in_valid = 1'b0; in_decrypt = 1'b0; out_ready = 1'b0; key = '0; data_in = '0;
        in_valid_m = 1'b0; in_decrypt_m = 1'b0; out_ready_m = 1'b0; key_m = '0; data_in_m = '0;
        #12;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_data_out", data_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(K1, P1, 1'b0);
        checkOutput("enc_run_status", status(busy, out_valid, in_ready), status(1, 0, 0));
        waitResult(20, cyc);
        checkOutput("enc_latency", 64'(cyc), 64'd16);
        checkOutput("enc_data", data_out, C1);

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_data", data_out, C1);
            checkOutput("bp_status", status(busy, out_valid, in_ready), status(1, 1, 0));
        end

        out_ready = 1'b1;
        applyStimulus(K1, C1, 1'b1);
        out_ready = 1'b0;
        checkOutput("b2b_status", status(busy, out_valid, in_ready), status(1, 0, 0));
        waitResult(20, cyc);
        checkOutput("dec_latency", 64'(cyc), 64'd16);
        checkOutput("dec_data", data_out, P1);

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("idle_status", status(busy, out_valid, in_ready), status(0, 0, 1));
`ifdef DES_ZEROIZE_EN
        checkOutput("post_handshake_data", data_out, 64'd0);
`else
        checkOutput("post_handshake_data", data_out, P1);
`endif

        applyStimulus(K1, P1, 1'b0);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_status", status(busy, out_valid, in_ready), status(0, 0, 1));
        checkOutput("midrst_data", data_out, 64'd0);
        ov_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            ov_seen = ov_seen | out_valid;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            ov_seen = ov_seen | out_valid;
        end
        checkOutput("midrst_no_valid", 64'(ov_seen), 64'd0);

        applyStimulus(K1, P1, 1'b0);
        waitResult(20, cyc);
        checkOutput("fresh_latency", 64'(cyc), 64'd16);
        checkOutput("fresh_data", data_out, C1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        for (int v = 0; v < 2; v++) begin
            key_m = vk[v];
            data_in_m = vp[v];
            in_decrypt_m = 1'b0;
            in_valid_m = 1'b1;
            @(posedge clk);
            #1;
            in_valid_m = 1'b0;
            for (int g = 0; g < 4; g++) lat[g] = 0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk);
                #1;
                for (int g = 0; g < 4; g++)
                    if (lat[g] == 0 && out_valid_m[g]) lat[g] = c;
            end
            for (int g = 0; g < 4; g++) begin
                checkOutput($sformatf("multi_latency_r%0d", RV[g]), 64'(lat[g]), 64'(16 / RV[g]));
                checkOutput($sformatf("multi_data_r%0d", RV[g]), data_out_m[g], vc[v]);
            end
            out_ready_m = 1'b1;
            @(posedge clk);
            #1;
            out_ready_m = 1'b0;
            for (int g = 0; g < 4; g++)
                checkOutput($sformatf("multi_idle_r%0d", RV[g]),
                            status(busy_m[g], out_valid_m[g], in_ready_m[g]), status(0, 0, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/des_iter_core.md
Name: des_iter_core

Overview:
- Sequential, iterative DES engine with a valid/ready handshake on both input and output.
- Supersedes the combinational DES_top/DES_decrypt pair with one core that handles both directions, selected per block.
- Performs ROUNDS_PER_CYCLE Feistel rounds per clock and is sized to sit behind a bus-facing crypto wrapper.

Parameters:
- ROUNDS_PER_CYCLE, 1, Feistel rounds unrolled per clock. Legal values are 1, 2, 4, 8 and 16; any other value is a compile-time error.

Ports:
- CLK  input  1  system clock, rising edge
- RST_N  input  1  asynchronous active-low reset
- IN_VALID  input  1  input block and key are valid
- IN_READY  output  1  core can accept a block
- IN_DECRYPT  input  1  0 = encrypt, 1 = decrypt; sampled at acceptance
- KEY  input  64  DES key with parity bits; parity is ignored
- DATA_IN  input  64  plaintext or ciphertext
- OUT_VALID  output  1  DATA_OUT is valid
- OUT_READY  input  1  downstream accepts DATA_OUT
- DATA_OUT  output  64  result
- BUSY  output  1  high in RUN or DONE

Behaviour:
- Reset (asynchronous, RST_N low):
  - State goes to IDLE.
  - IN_READY=1, OUT_VALID=0, BUSY=0, DATA_OUT=0.
  - L, R, C, D, round counter and latched mode all clear to 0.
  - Reset asserted mid-RUN or mid-DONE abandons the block; no output is produced.
- States are IDLE, RUN and DONE; N = 16/ROUNDS_PER_CYCLE.
- IDLE:
  - IN_READY=1.
  - Acceptance is IN_VALID & IN_READY at a rising edge.
  - On acceptance: {L,R} <= IP(DATA_IN), {C,D} <= PC1(KEY), mode <= IN_DECRYPT, cnt <= 0, go to RUN.
- RUN:
  - IN_READY=0.
  - Each edge applies ROUNDS_PER_CYCLE rounds and advances cnt by ROUNDS_PER_CYCLE.
  - When cnt reaches 16, the final swap and FP are registered into DATA_OUT and the state goes to DONE.
  - OUT_VALID is high exactly N edges after the acceptance edge: 16 cycles for R=1, 1 cycle for R=16.
- Key schedule:
  - Encrypt: before rounds 1, 2, 9 and 16, rotate C and D left by 1; before all other rounds, rotate left by 2.
  - Decrypt: no rotation before round 1; before rounds 2, 9 and 16, rotate right by 1; before all other rounds, rotate right by 2.
  - PC2 is applied to {C,D} to form each 48-bit subkey.
- DONE:
  - OUT_VALID=1; DATA_OUT is held stable until OUT_READY=1.
  - IN_READY = OUT_READY, which allows back-to-back operation.
  - On an OUT_READY edge with IN_VALID=1, the new block is accepted, same as the IDLE acceptance, and the state goes to RUN.
  - On an OUT_READY edge with IN_VALID=0, the state goes to IDLE.
- IN_VALID, KEY, DATA_IN and IN_DECRYPT are don't-care when IN_READY=0. Inputs changing during RUN have no effect.
- DES bit numbering: bit 1 of the standard is bit 63 of the ports.

Optional Feature:
- Macro: DES_ZEROIZE_EN.
- Defined:
  - On the output handshake edge, DATA_OUT is cleared to 0, unless a new block is accepted on the same edge.
  - When DONE is left for IDLE, L, R, C and D are cleared to 0.
  - In IDLE, DATA_OUT reads 0.
- Undefined: DATA_OUT and the internal registers keep their last values after the handshake.

Decomposition:
- Package des_pkg holds:
  - IP, FP, E, P, PC1 and PC2 tables.
  - The eight S-box constants.
  - The 16-entry shift schedule.
  - A state enum: IDLE, RUN, DONE.
  - Helper functions ip(), fp(), pc1(), pc2().
- Sub-module des_round is combinational:
  - Inputs: L, R, C, D, round index, mode.
  - Outputs: next L, R, C, D.
  - Instantiated ROUNDS_PER_CYCLE times in a generate chain.

Test Plan:
- Encrypt, R=1: KEY=133457799BBCDFF1, DATA_IN=0123456789ABCDEF -> DATA_OUT=85E813540F0AB405; OUT_VALID exactly 16 cycles after acceptance.
- Decrypt, R=1: same KEY, DATA_IN=85E813540F0AB405, IN_DECRYPT=1 -> DATA_OUT=0123456789ABCDEF.
- Encrypt, R=16: KEY=0E329232EA6D0D73, DATA_IN=8787878787878787 -> 0000000000000000 one cycle after acceptance. Repeat for R=2, 4, 8 with latencies 8, 4, 2.
- Backpressure: hold OUT_READY=0 for 10 cycles -> OUT_VALID and DATA_OUT stable and IN_READY=0. Then OUT_READY=1 with IN_VALID=1 -> the second block is accepted on the same edge and its correct result follows N cycles later.
- Reset mid-RUN: assert RST_N=0 at round 7 -> outputs immediately at reset values, no OUT_VALID pulse. After release, a fresh block encrypts correctly.
- DES_ZEROIZE_EN defined: after the output handshake, DATA_OUT==0 on the next cycle. Macro undefined: DATA_OUT retains 85E813540F0AB405.
